mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- EX-stage multiply/divide unit with HI/LO registers for the MIPS pipeline.
- Consumes the multiply/divide control fields produced by the ID/EX pipeline register: MDOpE, StartE, MDWeE, HiLoE, and the forwarded RS/RT operands.
- Runs mult/multu/div/divu over a fixed multi-cycle latency, holds Busy for the hazard unit, and serves mthi/mtlo/mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu (must be >=1).
- DIV_CYCLES, 10, cycles Busy stays high for div/divu (must be >=1).

Ports:
- Clk  input  1  pipeline clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- Start  input  1  launch operation in MDOp this cycle (from StartE).
- MDOp  input  3  000 mult, 001 multu, 010 div, 011 divu, others reserved.
- MDWe  input  1  mthi/mtlo write strobe (from MDWeE).
- HiLo  input  1  1 selects HI, 0 selects LO, for both write and read.
- D1  input  32  RS operand: dividend/multiplicand; mthi/mtlo data.
- D2  input  32  RT operand: divisor/multiplier.
- Busy  output  1  operation in flight.
- Done  output  1  one-cycle pulse in the cycle after HI/LO are updated by an operation.
- HI  output  32  HI register.
- LO  output  32  LO register.
- MDOut  output  32  HiLo ? HI : LO, combinational (mfhi/mflo data).

Behaviour:
- Reset (async, Reset_n=0): Busy=0, Done=0, HI=0, LO=0, counter=0, latched operands/op cleared. Any in-flight result is discarded.
- States: IDLE (Busy=0) and RUN (Busy=1). Counter is wide enough for max(MULT_CYCLES, DIV_CYCLES).
- IDLE, rising edge with Start=1 and a valid MDOp (000..011):
  - latch D1, D2, MDOp;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- IDLE, Start=1 with a reserved MDOp: ignored, stay IDLE.
- RUN: counter decrements each edge. On the edge where counter==1:
  - write HI/LO from the latched operands;
  - Busy goes to 0 and Done goes to 1 for exactly one cycle.
  - Busy is therefore high for exactly N cycles, starting the cycle after the Start edge.
- Start while Busy=1: ignored. The hazard unit stalls ID on Start|Busy, so this is illegal but must be harmless.
- MDWe in IDLE with Start=0: at the edge, HI<=D1 if HiLo=1, else LO<=D1.
- MDWe ignored when Busy=1 or Start=1 in the same cycle. Start has priority.
- Results always come from the latched operands; D1/D2 changes during RUN have no effect.
- mult: {HI,LO} = signed 64-bit product of signed D1 and signed D2.
- multu: {HI,LO} = unsigned 64-bit product.
- div: LO = signed quotient, truncated toward zero; HI = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: LO = unsigned quotient, HI = unsigned remainder.
- Divisor 0 (div/divu): full DIV_CYCLES busy period and Done pulse occur, but HI/LO keep their prior values.
- MDOut, HI, LO are not bypassed: during RUN they show the old HI/LO.
- Done is 0 except in the single cycle after completion.
- Back-to-back operations:
  - Start may be accepted in the cycle Busy first reads 0, i.e. the cycle Done=1.
  - The new op sees the updated HI/LO only through its own result; HI/LO are overwritten at its completion.

Test Plan:
- Reset mid-RUN: start div, pull Reset_n low at cycle 4 -> Busy=0, HI=LO=0 immediately; no Done pulse afterwards.
- mult D1=0xFFFFFFFE (-2), D2=0x00000003 -> Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, Done high 1 cycle.
- multu D1=0xFFFFFFFF, D2=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div D1=0xFFFFFFF9 (-7), D2=2 -> Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu D1=7, D2=0 with HI/LO preloaded 0x11/0x22 -> HI/LO unchanged, Done still pulses after 10 cycles.
- mthi D1=0xDEADBEEF, HiLo=1 in IDLE -> HI=0xDEADBEEF, MDOut=0xDEADBEEF.
  - mtlo asserted with Busy=1 -> LO unchanged.
  - Start and MDWe in the same cycle -> op starts, no write.
- Start asserted during RUN with a different D1/D2 -> ignored; the original result is written; Busy length unchanged.
- Reserved MDOp=3'b111 with Start=1 -> Busy stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit with HI/LO registers for the MIPS pipeline.
// Results are computed from latched operands and committed after a fixed latency.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic        MDWe,
    input  logic        HiLo,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    op_q, op_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic          done_q, done_d;

    logic signed [63:0] sA, sB, prodS;
    logic [63:0]        prodU;
    logic [31:0]        absA, absB, divisor, qU, rU, qS, rS;
    logic               divByZero;

    // Signed division works on magnitudes so that 0x80000000 / -1 wraps cleanly.
    always_comb begin
        sA        = {{32{a_q[31]}}, a_q};
        sB        = {{32{b_q[31]}}, b_q};
        prodS     = sA * sB;
        prodU     = {32'd0, a_q} * {32'd0, b_q};
        divByZero = (b_q == 32'd0);
        absA      = (op_q[0] == 1'b0 && a_q[31]) ? (~a_q + 32'd1) : a_q;
        absB      = (op_q[0] == 1'b0 && b_q[31]) ? (~b_q + 32'd1) : b_q;
        divisor   = divByZero ? 32'd1 : absB;
        qU        = absA / divisor;
        rU        = absA % divisor;
        qS        = (a_q[31] ^ b_q[31]) ? (~qU + 32'd1) : qU;
        rS        = a_q[31] ? (~rU + 32'd1) : rU;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (!MDOp[2]) begin
                        op_d    = MDOp[1:0];
                        a_d     = D1;
                        b_d     = D2;
                        cnt_d   = MDOp[1] ? DIV_LOAD : MULT_LOAD;
                        state_d = RUN;
                    end
                end else if (MDWe) begin
                    if (HiLo) hi_d = D1;
                    else      lo_d = D1;
                end
            end
            RUN: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    case (op_q)
                        2'b00: {hi_d, lo_d} = prodS;
                        2'b01: {hi_d, lo_d} = prodU;
                        2'b10: if (!divByZero) begin hi_d = rS; lo_d = qS; end
                        default: if (!divByZero) begin hi_d = rU; lo_d = qU; end
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 2'b00;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign Busy  = (state_q == RUN);
    assign Done  = done_q;
    assign HI    = hi_q;
    assign LO    = lo_q;
    assign MDOut = HiLo ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: table of arithmetic vectors plus
// hand-written sequences for hazards, back-to-back issue and mid-run reset.
module tb_mult_div_unit;

    logic        Clk, Reset_n, Start, MDWe, HiLo;
    logic [2:0]  MDOp;
    logic [31:0] D1, D2;
    logic        Busy, Done;
    logic [31:0] HI, LO, MDOut;

    int vecCount = 0;
    int errCount = 0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .MDOp(MDOp), .MDWe(MDWe),
        .HiLo(HiLo), .D1(D1), .D2(D2), .Busy(Busy), .Done(Done),
        .HI(HI), .LO(LO), .MDOut(MDOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, preHi, preLo, expHi, expLo;
        int          cycles;
    } vec_t;

    vec_t vecs[9];

    // Comparison helper; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic writeHiLo(input logic sel, input logic [31:0] data);
        HiLo = sel; D1 = data; MDWe = 1'b1;
        tick();
        MDWe = 1'b0;
    endtask

    // Launch an operation and then scramble the operand buses.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        MDOp = op; D1 = a; D2 = b; Start = 1'b1;
        tick();
        Start = 1'b0;
        D1 = 32'hCAFEF00D;
        D2 = 32'h13579BDF;
    endtask

    task automatic waitIdle(output int n);
        n = 0;
        while (Busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        int pulses;

        vecs[0] = '{3'b000, 32'hFFFFFFFE, 32'h00000003, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[2] = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{3'b011, 32'h00000007, 32'h00000000, 32'h11, 32'h22, 32'h00000011, 32'h00000022, 10};
        vecs[4] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h6, 32'h00000000, 32'h80000000, 10};
        vecs[5] = '{3'b011, 32'h00000064, 32'h00000007, 32'h0, 32'h0, 32'h00000002, 32'h0000000E, 10};
        vecs[6] = '{3'b000, 32'h00010000, 32'h00010000, 32'h0, 32'h0, 32'h00000001, 32'h00000000, 5};
        vecs[7] = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[8] = '{3'b010, 32'h00000005, 32'h00000000, 32'hAA, 32'hBB, 32'h000000AA, 32'h000000BB, 10};

        Reset_n = 1'b0; Start = 1'b0; MDWe = 1'b0; HiLo = 1'b0; MDOp = 3'b000;
        D1 = 32'h0; D2 = 32'h0;
        #3;
        checkOutput("reset Busy", {31'd0, Busy}, 32'd0);
        checkOutput("reset Done", {31'd0, Done}, 32'd0);
        checkOutput("reset HI", HI, 32'd0);
        checkOutput("reset LO", LO, 32'd0);
        #9 Reset_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            writeHiLo(1'b1, vecs[i].preHi);
            writeHiLo(1'b0, vecs[i].preLo);
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            checkOutput($sformatf("v%0d busy", i), {31'd0, Busy}, 32'd1);
            checkOutput($sformatf("v%0d HI held", i), HI, vecs[i].preHi);
            waitIdle(n);
            checkOutput($sformatf("v%0d cycles", i), n, vecs[i].cycles);
            checkOutput($sformatf("v%0d done", i), {31'd0, Done}, 32'd1);
            checkOutput($sformatf("v%0d HI", i), HI, vecs[i].expHi);
            checkOutput($sformatf("v%0d LO", i), LO, vecs[i].expLo);
            HiLo = 1'b1; #1;
            checkOutput($sformatf("v%0d mfhi", i), MDOut, vecs[i].expHi);
            HiLo = 1'b0; #1;
            checkOutput($sformatf("v%0d mflo", i), MDOut, vecs[i].expLo);
            tick();
            checkOutput($sformatf("v%0d done clr", i), {31'd0, Done}, 32'd0);
        end

        // mthi / mtlo in IDLE
        writeHiLo(1'b1, 32'hDEADBEEF);
        HiLo = 1'b1; #1;
        checkOutput("mthi HI", HI, 32'hDEADBEEF);
        checkOutput("mthi MDOut", MDOut, 32'hDEADBEEF);
        writeHiLo(1'b0, 32'h00000055);
        checkOutput("mtlo LO", LO, 32'h00000055);

        // mtlo while busy must be dropped
        applyStimulus(3'b001, 32'd2, 32'd3);
        HiLo = 1'b0; D1 = 32'h00000BAD; MDWe = 1'b1;
        tick();
        MDWe = 1'b0;
        checkOutput("busy mtlo LO", LO, 32'h00000055);
        waitIdle(n);
        checkOutput("busy mtlo result", LO, 32'd6);

        // Start and MDWe together: op starts, no write
        writeHiLo(1'b1, 32'h00000077);
        HiLo = 1'b1; MDWe = 1'b1;
        applyStimulus(3'b001, 32'd2, 32'd3);
        MDWe = 1'b0;
        checkOutput("start+we busy", {31'd0, Busy}, 32'd1);
        checkOutput("start+we HI", HI, 32'h00000077);
        waitIdle(n);
        checkOutput("start+we HI res", HI, 32'd0);
        checkOutput("start+we LO res", LO, 32'd6);

        // Start during RUN is ignored; then back-to-back start in the Done cycle
        applyStimulus(3'b000, 32'd3, 32'd4);
        tick();
        tick();
        MDOp = 3'b000; D1 = 32'd100; D2 = 32'd100; Start = 1'b1;
        tick();
        Start = 1'b0;
        waitIdle(n);
        checkOutput("restart cycles", 3 + n, 32'd5);
        checkOutput("restart LO", LO, 32'd12);
        checkOutput("restart done", {31'd0, Done}, 32'd1);
        applyStimulus(3'b001, 32'd5, 32'd6);
        checkOutput("b2b busy", {31'd0, Busy}, 32'd1);
        checkOutput("b2b done clr", {31'd0, Done}, 32'd0);
        waitIdle(n);
        checkOutput("b2b cycles", n, 32'd5);
        checkOutput("b2b LO", LO, 32'd30);

        // Reserved opcode
        applyStimulus(3'b111, 32'd9, 32'd9);
        checkOutput("rsvd busy", {31'd0, Busy}, 32'd0);
        checkOutput("rsvd LO", LO, 32'd30);
        tick();
        checkOutput("rsvd done", {31'd0, Done}, 32'd0);

        // Asynchronous reset in the middle of a divide
        applyStimulus(3'b011, 32'd100, 32'd7);
        tick();
        tick();
        tick();
        #2 Reset_n = 1'b0;
        #1;
        checkOutput("rst busy", {31'd0, Busy}, 32'd0);
        checkOutput("rst HI", HI, 32'd0);
        checkOutput("rst LO", LO, 32'd0);
        #2 Reset_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (Done || Busy) pulses++;
        end
        checkOutput("rst no done", pulses, 32'd0);
        checkOutput("rst LO after", LO, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
